// File: rtl/class_merge_arbiter_pkg.sv
// Shared class-layer definitions: word geometry, class-bit position and the
// merge-arbiter FSM encoding used alongside the class demux / FIFO path.
package class_merge_arbiter_pkg;

  // Default word width; the class bit is always the MSB of a word.
  localparam int DATA_SIZE_DEF = 10;
  localparam int CLASS_BIT_DEF = DATA_SIZE_DEF - 1;

  // Credit counter width; weights are limited to 1..15.
  localparam int CREDIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2,
    PAUSE  = 2'd3
  } arb_state_e;

  // Converts a weight parameter into a credit value.
  function automatic logic [CREDIT_W-1:0] weight_credit(input int weight);
    return CREDIT_W'(weight);
  endfunction

endpackage

// File: rtl/class_merge_arbiter_if.sv
// Bundle of the upstream FIFO, downstream flow-control and status signals of
// the class merge arbiter. master = arbiter side, slave = environment side.
interface class_merge_arbiter_if
  import class_merge_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int MAIN_SIZE = 8
);

  logic [DATA_SIZE-1:0] data_in0;
  logic [DATA_SIZE-1:0] data_in1;
  logic                 fifo_empty0;
  logic                 fifo_empty1;
  logic                 AF_down;
  logic                 Full_down;
  logic                 pop0;
  logic                 pop1;
  logic [DATA_SIZE-1:0] out;
  logic                 valid_out;
  logic [MAIN_SIZE-1:0] cnt0;
  logic [MAIN_SIZE-1:0] cnt1;
  logic                 Error;

  modport master (
    input  data_in0, data_in1, fifo_empty0, fifo_empty1, AF_down, Full_down,
    output pop0, pop1, out, valid_out, cnt0, cnt1, Error
  );

  modport slave (
    output data_in0, data_in1, fifo_empty0, fifo_empty1, AF_down, Full_down,
    input  pop0, pop1, out, valid_out, cnt0, cnt1, Error
  );

endinterface

// File: rtl/class_merge_arbiter_credit.sv
// Grant credit counter for the merge arbiter: loads a weight on a grant,
// counts down one per pop, and parks/restores its value across a pause.
module arb_credit_counter
  import class_merge_arbiter_pkg::*;
#(
  parameter int WIDTH = CREDIT_W
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             save,
  input  logic             restore,
  output logic [WIDTH-1:0] credit
);

  logic [WIDTH-1:0] saved;

  // Load beats restore beats decrement: a grant on the last pop must start
  // the new turn with a full weight, not weight-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit <= '0;
    end else if (load) begin
      credit <= load_val;
    end else if (restore) begin
      credit <= saved;
    end else if (dec && credit != '0) begin
      credit <= credit - WIDTH'(1);
    end
  end

  // Snapshot of the remaining credit taken on entry to PAUSE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      saved <= '0;
    end else if (save) begin
      saved <= credit;
    end
  end

endmodule

// File: rtl/class_merge_arbiter.sv
// Weighted round-robin merger of the class-0 and class-1 FIFOs into one
// stream. Pops are combinational; data returns from the FIFO one cycle later
// and is registered here, giving two cycles from pop to valid_out.
module class_merge_arbiter
  import class_merge_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int MAIN_SIZE = 8,
  parameter int WEIGHT0   = 4,
  parameter int WEIGHT1   = 2
)(
  input  logic clk,
  input  logic reset,
  class_merge_arbiter_if.master bus
);

  localparam int CLS = DATA_SIZE - 1;
  localparam logic [CREDIT_W-1:0] W0 = weight_credit(WEIGHT0);
  localparam logic [CREDIT_W-1:0] W1 = weight_credit(WEIGHT1);

  arb_state_e state, next_state, saved_state;
  logic       last_served;

  logic pause_cond;
  logic e0, e1;
  logic pop0, pop1, any_pop, last_pop;

  logic                load, save, restore;
  logic [CREDIT_W-1:0] load_val, credit;

  logic                 pop0_q, pop1_q;
  logic [DATA_SIZE-1:0] out_r;
  logic                 valid_r;
  logic                 out_cls;
  logic [MAIN_SIZE-1:0] cnt0_r, cnt1_r;
  logic                 err_r;

  assign pause_cond = bus.AF_down | bus.Full_down;
  assign e0         = bus.fifo_empty0;
  assign e1         = bus.fifo_empty1;

  // Only one SERVE state can be active, so the two pops are exclusive.
  assign pop0     = (state == SERVE0) & ~e0 & ~pause_cond;
  assign pop1     = (state == SERVE1) & ~e1 & ~pause_cond;
  assign any_pop  = pop0 | pop1;
  assign last_pop = any_pop & (credit == CREDIT_W'(1));

  arb_credit_counter #(.WIDTH(CREDIT_W)) u_credit (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (any_pop),
    .save     (save),
    .restore  (restore),
    .credit   (credit)
  );

  // Next-state and credit control. Pause overrides everything outside PAUSE;
  // a turn ends on its last credited pop or when its FIFO runs dry, and the
  // other class is preferred for the next turn.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = '0;
    save       = 1'b0;
    restore    = 1'b0;
    if (state != PAUSE && pause_cond) begin
      next_state = PAUSE;
      save       = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!e0 && !e1) begin
            load = 1'b1;
            if (last_served) begin
              next_state = SERVE0;
              load_val   = W0;
            end else begin
              next_state = SERVE1;
              load_val   = W1;
            end
          end else if (!e0) begin
            next_state = SERVE0;
            load       = 1'b1;
            load_val   = W0;
          end else if (!e1) begin
            next_state = SERVE1;
            load       = 1'b1;
            load_val   = W1;
          end
        end
        SERVE0: begin
          if (e0 || last_pop) begin
            if (!e1) begin
              next_state = SERVE1;
              load       = 1'b1;
              load_val   = W1;
            end else if (!e0) begin
              next_state = SERVE0;
              load       = 1'b1;
              load_val   = W0;
            end else begin
              next_state = IDLE;
            end
          end
        end
        SERVE1: begin
          if (e1 || last_pop) begin
            if (!e0) begin
              next_state = SERVE0;
              load       = 1'b1;
              load_val   = W0;
            end else if (!e1) begin
              next_state = SERVE1;
              load       = 1'b1;
              load_val   = W1;
            end else begin
              next_state = IDLE;
            end
          end
        end
        PAUSE: begin
          if (!pause_cond) begin
            next_state = saved_state;
            restore    = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State register plus the state parked across a pause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      saved_state <= IDLE;
    end else begin
      state <= next_state;
      if (save) saved_state <= state;
    end
  end

  // Remembers the class being served; reset value makes class 0 win first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_served <= 1'b1;
    end else if (state == SERVE0) begin
      last_served <= 1'b0;
    end else if (state == SERVE1) begin
      last_served <= 1'b1;
    end
  end

  // Pop tracking and output capture: data_in is valid the cycle after a pop.
  // Clearing the pop flags on reset drops any word still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop0_q  <= 1'b0;
      pop1_q  <= 1'b0;
      valid_r <= 1'b0;
      out_r   <= '0;
      out_cls <= 1'b0;
    end else begin
      pop0_q  <= pop0;
      pop1_q  <= pop1;
      valid_r <= pop0_q | pop1_q;
      if (pop0_q | pop1_q) begin
        out_r   <= pop1_q ? bus.data_in1 : bus.data_in0;
        out_cls <= pop1_q;
      end
    end
  end

  // Delivered-word counters, attributed to the source port, not the class bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else begin
      if (pop0_q) cnt0_r <= cnt0_r + MAIN_SIZE'(1);
      if (pop1_q) cnt1_r <= cnt1_r + MAIN_SIZE'(1);
    end
  end

  // Sticky mismatch flag: the delivered word's class bit disagrees with its port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (valid_r && (out_r[CLS] != out_cls)) begin
      err_r <= 1'b1;
    end
  end

  assign bus.pop0      = pop0;
  assign bus.pop1      = pop1;
  assign bus.out       = out_r;
  assign bus.valid_out = valid_r;
  assign bus.cnt0      = cnt0_r;
  assign bus.cnt1      = cnt1_r;
  assign bus.Error     = err_r;

endmodule

// File: tb/tb_class_merge_arbiter.sv
// Directed bench for class_merge_arbiter with two behavioural read-latency-1
// FIFOs in front of it.
module tb_class_merge_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  class_merge_arbiter_if #(.DATA_SIZE(10), .MAIN_SIZE(8)) bus();

  class_merge_arbiter #(
    .DATA_SIZE(10), .MAIN_SIZE(8), .WEIGHT0(4), .WEIGHT1(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Upstream FIFO models: free-running pointers, data registered on pop.
  logic [9:0] mem0 [0:1023];
  logic [9:0] mem1 [0:1023];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  logic [9:0] d0 = '0, d1 = '0;

  always @(posedge clk) begin
    if (bus.pop0) begin d0 <= mem0[rd0 % 1024]; rd0 <= rd0 + 1; end
    if (bus.pop1) begin d1 <= mem1[rd1 % 1024]; rd1 <= rd1 + 1; end
  end

  assign bus.data_in0    = d0;
  assign bus.data_in1    = d1;
  assign bus.fifo_empty0 = (rd0 == wr0);
  assign bus.fifo_empty1 = (rd1 == wr1);

  // Output monitor.
  logic [9:0] got[$];
  bit both_pop = 0;
  always @(negedge clk) begin
    if (bus.valid_out) got.push_back(bus.out);
    if (bus.pop0 && bus.pop1) both_pop = 1;
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic push0(input logic [9:0] w); mem0[wr0 % 1024] = w; wr0++; endtask
  task automatic push1(input logic [9:0] w); mem1[wr1 % 1024] = w; wr1++; endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.AF_down = 1'b0;
    bus.Full_down = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    got.delete();
    both_pop = 0;
  endtask

  task automatic test_reset();
    bus.AF_down = 1'b0;
    bus.Full_down = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus.out !== 10'h000) begin n_fail++; $display("FAIL reset_out: got %h want 000", bus.out); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.cnt0 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt0: got %0d want 0", bus.cnt0); end
    n_cmp++; if (bus.cnt1 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt1: got %0d want 0", bus.cnt1); end
    n_cmp++; if (bus.Error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", bus.Error); end
    n_cmp++; if ({bus.pop0, bus.pop1} !== 2'b00) begin n_fail++; $display("FAIL reset_pops: got %b want 00", {bus.pop0, bus.pop1}); end
  endtask

  // Both FIFOs hold 8 words: 4xC0, 2xC1, 4xC0, 2xC1, 4xC1.
  task automatic test_merge_order();
    bit cls_seq [16] = '{0,0,0,0,1,1,0,0,0,0,1,1,1,1,1,1};
    logic [9:0] exp_w;
    int i0 = 0, i1 = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin push0(10'h040 + 10'(i)); push1(10'h240 + 10'(i)); end
    for (int c = 0; c < 200 && got.size() < 16; c++) tick();
    repeat (6) tick();
    n_cmp++; if (got.size() != 16) begin n_fail++; $display("FAIL merge_count: got %0d words want 16", got.size()); end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      if (cls_seq[k]) begin exp_w = 10'h240 + 10'(i1); i1++; end
      else begin exp_w = 10'h040 + 10'(i0); i0++; end
      n_cmp++; if (got[k] !== exp_w) begin n_fail++; $display("FAIL merge_word[%0d]: got %h want %h", k, got[k], exp_w); end
    end
    n_cmp++; if (bus.cnt0 !== 8'd8) begin n_fail++; $display("FAIL merge_cnt0: got %0d want 8", bus.cnt0); end
    n_cmp++; if (bus.cnt1 !== 8'd8) begin n_fail++; $display("FAIL merge_cnt1: got %0d want 8", bus.cnt1); end
    n_cmp++; if (both_pop !== 1'b0) begin n_fail++; $display("FAIL merge_pop_excl: got %b want 0", both_pop); end
  endtask

  // Only FIFO1 holds 3 words: pop1 N..N+2, valid_out N+2..N+4.
  task automatic test_single_class();
    bit p0 [24], p1 [24], vo [24];
    logic [9:0] ov [24];
    logic [9:0] w [3] = '{10'h2A1, 10'h2A2, 10'h2A3};
    int n = -1;
    apply_reset();
    for (int i = 0; i < 3; i++) push1(w[i]);
    for (int r = 0; r < 24; r++) begin
      @(negedge clk);
      p0[r] = bus.pop0; p1[r] = bus.pop1; vo[r] = bus.valid_out; ov[r] = bus.out;
    end
    for (int r = 0; r < 12; r++) if (n < 0 && p1[r]) n = r;
    n_cmp++; if (n < 0) begin n_fail++; $display("FAIL single_first_pop: no pop1 within 12 cycles"); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (p1[n+k] !== (k < 3)) begin n_fail++; $display("FAIL single_pop1[N+%0d]: got %b want %b", k, p1[n+k], (k < 3)); end
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (vo[n+2+k] !== 1'b1) begin n_fail++; $display("FAIL single_valid[N+%0d]: got %b want 1", k+2, vo[n+2+k]); end
        n_cmp++; if (ov[n+2+k] !== w[k]) begin n_fail++; $display("FAIL single_data[N+%0d]: got %h want %h", k+2, ov[n+2+k], w[k]); end
      end
      n_cmp++; if (vo[n+5] !== 1'b0) begin n_fail++; $display("FAIL single_valid[N+5]: got %b want 0", vo[n+5]); end
    end
    n_cmp++; if (p0.or() !== 1'b0) begin n_fail++; $display("FAIL single_pop0: got 1 want never"); end
  endtask

  // AF_down after 2 C0 pops: pause, in-flight word delivered, 2 credits left.
  task automatic test_pause();
    logic [9:0] exp_w [10] = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h220, 10'h221,
                               10'h014, 10'h015, 10'h016, 10'h017};
    int c = 0, n = 0;
    bit saw1 = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) push0(10'h010 + 10'(i));
    push1(10'h220); push1(10'h221);
    for (int t = 0; t < 20 && c < 2; t++) begin @(negedge clk); if (bus.pop0) c++; end
    n_cmp++; if (c != 2) begin n_fail++; $display("FAIL pause_two_pops: got %0d pops want 2", c); end
    tick();
    bus.AF_down = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.pop0 !== 1'b0) begin n_fail++; $display("FAIL pause_pop0_same_cycle: got %b want 0", bus.pop0); end
    repeat (4) tick();
    n_cmp++; if ({bus.pop0, bus.pop1} !== 2'b00) begin n_fail++; $display("FAIL pause_pops_held: got %b want 00", {bus.pop0, bus.pop1}); end
    n_cmp++; if (got.size() != 2) begin n_fail++; $display("FAIL pause_inflight: got %0d words want 2", got.size()); end
    bus.AF_down = 1'b0;
    for (int t = 0; t < 20 && !saw1; t++) begin
      @(negedge clk);
      if (bus.pop1) saw1 = 1; else if (bus.pop0) n++;
    end
    n_cmp++; if (!saw1 || n != 2) begin n_fail++; $display("FAIL pause_resume_credit: got %0d C0 pops before C1 want 2", n); end
    for (int t = 0; t < 40 && got.size() < 10; t++) tick();
    n_cmp++; if (got.size() != 10) begin n_fail++; $display("FAIL pause_count: got %0d words want 10", got.size()); end
    for (int k = 0; k < 10 && k < got.size(); k++) begin
      n_cmp++; if (got[k] !== exp_w[k]) begin n_fail++; $display("FAIL pause_word[%0d]: got %h want %h", k, got[k], exp_w[k]); end
    end
  endtask

  // Class-0 word on port 1: Error sets one cycle after it shows on out, sticks.
  task automatic test_error();
    bit found = 0;
    apply_reset();
    push1(10'h0A5);
    for (int t = 0; t < 20 && !found; t++) begin @(negedge clk); if (bus.valid_out) found = 1; end
    n_cmp++; if (!found || bus.out !== 10'h0A5) begin n_fail++; $display("FAIL error_word: got %h want 0a5", bus.out); end
    n_cmp++; if (bus.Error !== 1'b0) begin n_fail++; $display("FAIL error_early: got %b want 0", bus.Error); end
    n_cmp++; if (bus.cnt1 !== 8'd1) begin n_fail++; $display("FAIL error_cnt1: got %0d want 1", bus.cnt1); end
    @(negedge clk);
    n_cmp++; if (bus.Error !== 1'b1) begin n_fail++; $display("FAIL error_set: got %b want 1", bus.Error); end
    push1(10'h2FF);
    repeat (8) @(negedge clk);
    n_cmp++; if (bus.Error !== 1'b1) begin n_fail++; $display("FAIL error_sticky: got %b want 1", bus.Error); end
    n_cmp++; if (bus.cnt1 !== 8'd2) begin n_fail++; $display("FAIL error_cnt1_after: got %0d want 2", bus.cnt1); end
    n_cmp++; if (bus.cnt0 !== 8'd0) begin n_fail++; $display("FAIL error_cnt0: got %0d want 0", bus.cnt0); end
  endtask

  // 256 C0 words wrap cnt0; then reset mid-burst clears everything at once.
  task automatic test_wrap_reset();
    bit found = 0;
    apply_reset();
    for (int i = 0; i < 256; i++) push0(10'(i));
    for (int t = 0; t < 1000 && got.size() < 256; t++) tick();
    repeat (4) tick();
    n_cmp++; if (got.size() != 256) begin n_fail++; $display("FAIL wrap_count: got %0d words want 256", got.size()); end
    n_cmp++; if (bus.cnt0 !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt0: got %0d want 0", bus.cnt0); end
    n_cmp++; if (bus.cnt1 !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt1: got %0d want 0", bus.cnt1); end
    for (int i = 0; i < 12; i++) push0(10'h101 + 10'(i));
    for (int i = 0; i < 8; i++) push1(10'h301 + 10'(i));
    repeat (8) tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.out !== 10'h000) begin n_fail++; $display("FAIL midreset_out: got %h want 000", bus.out); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.cnt0 !== 8'd0) begin n_fail++; $display("FAIL midreset_cnt0: got %0d want 0", bus.cnt0); end
    n_cmp++; if (bus.cnt1 !== 8'd0) begin n_fail++; $display("FAIL midreset_cnt1: got %0d want 0", bus.cnt1); end
    n_cmp++; if ({bus.pop0, bus.pop1} !== 2'b00) begin n_fail++; $display("FAIL midreset_pops: got %b want 00", {bus.pop0, bus.pop1}); end
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.pop0, bus.pop1} !== 2'b00) begin n_fail++; $display("FAIL release_no_pop: got %b want 00", {bus.pop0, bus.pop1}); end
    for (int t = 0; t < 10 && !found; t++) begin @(negedge clk); if (bus.pop0 || bus.pop1) found = 1; end
    n_cmp++; if (!found || {bus.pop0, bus.pop1} !== 2'b10) begin n_fail++; $display("FAIL release_first_grant: got %b want 10", {bus.pop0, bus.pop1}); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.valid_out !== 1'b1 || bus.out[9] !== 1'b0) begin n_fail++; $display("FAIL release_first_word: got v=%b out=%h want class-0 word", bus.valid_out, bus.out); end
  endtask

  initial begin
    bus.AF_down = 1'b0;
    bus.Full_down = 1'b0;
    test_reset();
    test_merge_order();
    test_single_class();
    test_pause();
    test_error();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
